// File: rtl/gpio_irq.sv
// gpio_irq: pin-change interrupt block on the GPIO input path.
// Synchronises, optionally debounces, and latches pin edges into pending bits.
module gpio_irq #(
  parameter int WIDTH  = 8,
  parameter int STABLE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       AD,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  input  logic             rw,
  input  logic             cs,
  output logic             irq,
  input  logic [WIDTH-1:0] pins
);

  typedef enum logic [2:0] {
    A_PIN   = 3'd0,
    A_RISE  = 3'd1,
    A_FALL  = 3'd2,
    A_PEND  = 3'd3,
    A_MASK  = 3'd4,
    A_DBDIV = 3'd5,
    A_RSV6  = 3'd6,
    A_RSV7  = 3'd7
  } addr_e;

  localparam logic [3:0] STB_LAST = 4'(STABLE - 1);

  logic [WIDTH-1:0]      sync1_q, sync2_q;
  logic [WIDTH-1:0]      filt_q, filt_d;
  logic [WIDTH-1:0]      prev_q;
  logic [WIDTH-1:0]      rise_q, rise_d;
  logic [WIDTH-1:0]      fall_q, fall_d;
  logic [WIDTH-1:0]      pend_q, pend_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [7:0]            div_q, div_d;
  logic [7:0]            pre_q, pre_d;
  logic [WIDTH-1:0][3:0] dcnt_q, dcnt_d;
  logic [7:0]            do_q, do_d;

  addr_e            addr;
  logic             wr, rd;
  logic             wr_rise, wr_fall, wr_pend;
  logic             wr_mask, wr_div;
  logic             bypass, tick;
  logic [WIDTH-1:0] filt, set, w1c;

  assign addr    = addr_e'(AD[2:0]);
  assign wr      = cs & ~rw;
  assign rd      = cs & rw;
  assign wr_rise = wr && (addr == A_RISE);
  assign wr_fall = wr && (addr == A_FALL);
  assign wr_pend = wr && (addr == A_PEND);
  assign wr_mask = wr && (addr == A_MASK);
  assign wr_div  = wr && (addr == A_DBDIV);

  assign bypass = (div_q == 8'd0);
  assign tick   = !bypass && (pre_q == div_q);
  assign filt   = bypass ? sync2_q : filt_q;

  assign set = (filt & ~prev_q & rise_q)
             | (~filt & prev_q & fall_q);
  assign w1c = wr_pend ? DI[WIDTH-1:0] : '0;

  assign irq = |(pend_q & mask_q);
  assign DO  = do_q;

  always_comb begin
    rise_d = wr_rise ? DI[WIDTH-1:0] : rise_q;
    fall_d = wr_fall ? DI[WIDTH-1:0] : fall_q;
    mask_d = wr_mask ? DI[WIDTH-1:0] : mask_q;
    div_d  = wr_div  ? DI : div_q;
    // set beats a same-cycle write-1-to-clear
    pend_d = (pend_q & ~w1c) | set;
  end

  always_comb begin
    pre_d = pre_q + 8'd1;
    if (wr_div || bypass || tick) begin
      pre_d = 8'd0;
    end
  end

  always_comb begin
    filt_d = filt_q;
    dcnt_d = dcnt_q;
    if (bypass) begin
      filt_d = sync2_q;
      dcnt_d = '0;
    end else if (wr_div) begin
      dcnt_d = '0;
    end else if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          dcnt_d[i] = 4'd0;
        end else if (dcnt_q[i] == STB_LAST) begin
          filt_d[i] = sync2_q[i];
          dcnt_d[i] = 4'd0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    do_d = 8'd0;
    unique case (addr)
      A_PIN:   do_d[WIDTH-1:0] = filt;
      A_RISE:  do_d[WIDTH-1:0] = rise_q;
      A_FALL:  do_d[WIDTH-1:0] = fall_q;
      A_PEND:  do_d[WIDTH-1:0] = pend_q;
      A_MASK:  do_d[WIDTH-1:0] = mask_q;
      A_DBDIV: do_d            = div_q;
      A_RSV6,
      A_RSV7:  do_d            = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      div_q   <= 8'd0;
      pre_q   <= 8'd0;
      dcnt_q  <= '0;
      do_q    <= 8'd0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      prev_q  <= filt;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      div_q   <= div_d;
      pre_q   <= pre_d;
      dcnt_q  <= dcnt_d;
      if (rd) begin
        do_q <= do_d;
      end
    end
  end

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed plus random bench for gpio_irq.
// Expected values come from a cycle-level behavioural model.
module tb_gpio_irq;

  localparam int STB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] AD = '0;
  logic [7:0] DI = '0;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       irq;
  logic [7:0] pins = '0;
  logic [7:0] cur = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gpio_irq #(.WIDTH(8), .STABLE(STB)) dut (
    .clk  (clk),
    .rst  (rst),
    .AD   (AD),
    .DI   (DI),
    .DO   (DO),
    .rw   (rw),
    .cs   (cs),
    .irq  (irq),
    .pins (pins)
  );

  // reference model state
  logic [7:0] m_p1, m_p2, m_filt, m_prev;
  logic [7:0] m_rise, m_fall, m_pend, m_mask;
  logic [7:0] m_div, m_do;
  int         m_run[8];
  int         m_phase;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a,
                                        input logic [7:0] f);
    case (a)
      3'd0:    return f;
      3'd1:    return m_rise;
      3'd2:    return m_fall;
      3'd3:    return m_pend;
      3'd4:    return m_mask;
      3'd5:    return m_div;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic c,
                            input logic rd_n, input logic [3:0] a,
                            input logic [7:0] d, input logic [7:0] p);
    logic [7:0] fnow, st;
    logic       wr, dbw, tk;
    if (r) begin
      {m_p1, m_p2, m_filt, m_prev} = '0;
      {m_rise, m_fall, m_pend, m_mask} = '0;
      m_div = 0; m_do = 0; m_phase = 0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      return;
    end
    fnow = (m_div == 0) ? m_p2 : m_filt;
    st = (fnow & ~m_prev & m_rise) | (~fnow & m_prev & m_fall);
    wr = c && !rd_n;
    dbw = wr && (a[2:0] == 3'd5);
    tk = (m_div != 0) && ((m_phase % (m_div + 1)) == m_div);
    if (c && rd_n) m_do = m_read(a[2:0], fnow);
    if (m_div == 0) begin
      m_filt = m_p2;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else if (dbw) begin
      for (int i = 0; i < 8; i++) m_run[i] = 0;
    end else if (tk) begin
      for (int i = 0; i < 8; i++) begin
        if (m_p2[i] != m_filt[i]) begin
          m_run[i]++;
          if (m_run[i] == STB) begin
            m_filt[i] = m_p2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    m_phase = dbw ? 0 : m_phase + 1;
    m_prev = fnow;
    if (wr && a[2:0] == 3'd3) m_pend = m_pend & ~d;
    m_pend = m_pend | st;
    if (wr && a[2:0] == 3'd1) m_rise = d;
    if (wr && a[2:0] == 3'd2) m_fall = d;
    if (wr && a[2:0] == 3'd4) m_mask = d;
    if (dbw) m_div = d;
    m_p2 = m_p1;
    m_p1 = p;
  endtask

  task automatic cyc(input logic r, input logic c,
                     input logic rd_n, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] p);
    @(negedge clk);
    rst = r; cs = c; rw = rd_n; AD = a; DI = d; pins = p;
    @(posedge clk);
    model_edge(r, c, rd_n, a, d, p);
    #1;
    chk("do", DO, m_do);
    chk("irq", {7'b0, irq}, {7'b0, |(m_pend & m_mask)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1, 4'd0, 8'd0, cur);
  endtask

  task automatic wrr(input logic [3:0] a, input logic [7:0] d);
    cyc(0, 1, 0, a, d, cur);
  endtask

  task automatic rdr(input logic [3:0] a);
    cyc(0, 1, 1, a, 8'd0, cur);
  endtask

  initial begin
    cyc(1, 0, 1, 4'd0, 8'd0, cur);
    for (int a = 0; a < 8; a++) begin
      rdr(4'(a));
      chk("rst_rd", DO, 8'h00);
    end
    chk("rst_irq", {7'b0, irq}, 8'h00);

    cur = 8'h5A; idle(3);
    wrr(4'd0, 8'hFF);
    rdr(4'd0);
    chk("pin_ro", DO, 8'h5A);
    cur = 8'h00; idle(3);

    wrr(4'd1, 8'h01); wrr(4'd4, 8'h01); idle(2);
    cur = 8'h01;
    idle(1); chk("byp_k", {7'b0, irq}, 8'h00);
    idle(1); chk("byp_k1", {7'b0, irq}, 8'h00);
    idle(1); chk("byp_k2", {7'b0, irq}, 8'h01);
    wrr(4'd3, 8'h01); chk("w1c_irq", {7'b0, irq}, 8'h00);
    rdr(4'd3); chk("w1c_pend", DO, 8'h00);

    cur = 8'h81; idle(3);
    wrr(4'd1, 8'h00); wrr(4'd2, 8'h80);
    wrr(4'd4, 8'h80); wrr(4'd3, 8'hFF);
    cur = 8'h01; idle(3);
    cur = 8'h81; idle(3);
    rdr(4'd3); chk("fall_pend", DO, 8'h80);
    chk("fall_irq", {7'b0, irq}, 8'h01);
    wrr(4'd4, 8'h00); chk("mask_irq", {7'b0, irq}, 8'h00);
    rdr(4'd3); chk("mask_pend", DO, 8'h80);

    cur = 8'h00;
    wrr(4'd2, 8'h00); wrr(4'd3, 8'hFF); wrr(4'd1, 8'h02);
    wrr(4'd4, 8'h02); wrr(4'd5, 8'h03); idle(6);
    cur = 8'h02; idle(8);
    cur = 8'h00; idle(20);
    rdr(4'd3); chk("db_glitch", DO, 8'h00);
    cur = 8'h02; idle(20);
    rdr(4'd3); chk("db_pend", DO, 8'h02);
    rdr(4'd0); chk("db_pin", DO, 8'h02);

    cur = 8'h00;
    wrr(4'd5, 8'h00); wrr(4'd1, 8'h04); wrr(4'd4, 8'h04);
    wrr(4'd3, 8'hFF); idle(2);
    cur = 8'h04; idle(3);
    cur = 8'h00; idle(3);
    cur = 8'h04; idle(2);
    wrr(4'd3, 8'h04); chk("coll_irq", {7'b0, irq}, 8'h01);
    rdr(4'd3); chk("coll_pend", DO & 8'h04, 8'h04);

    wrr(4'd1, 8'hFF); wrr(4'd2, 8'hFF);
    cur = 8'hFB; idle(3);
    cur = 8'h00; idle(3);
    wrr(4'd4, 8'hFF); wrr(4'd5, 8'h05);
    rdr(4'd3); chk("pre_rst_pend", DO, 8'hFF);
    cyc(1, 1, 0, 4'd3, 8'h00, cur);
    chk("rst_irq2", {7'b0, irq}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cur = ~cur; idle(3);
    end
    for (int a = 0; a < 8; a++) rdr(4'(a));
    rdr(4'd3); chk("rst_pend", DO, 8'h00);

    for (int n = 0; n < 3000; n++) begin
      logic       r, c, rn;
      logic [3:0] a;
      logic [7:0] d;
      r  = ($urandom_range(0, 499) == 0);
      c  = $urandom_range(0, 1) == 1;
      rn = $urandom_range(0, 1) == 1;
      a  = 4'($urandom);
      d  = 8'($urandom);
      if (a[2:0] == 3'd5) d = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) cur = 8'($urandom);
      cyc(r, c, rn, a, d, cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
